// File: rtl/mips_mc_ctrl_if.sv
// Control/status bundle between the multicycle MIPS main controller and its datapath.
// The master side is the controller; the slave side is the datapath (or a bench).
interface mips_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       Op;
    logic [5:0]       Funct;
    logic             zero;

    logic [3:0]       p_state;
    logic             PCEn;
    logic             IorD;
    logic             MemWrite;
    logic             IRWrite;
    logic             RegDst;
    logic             MemtoReg;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [2:0]       ALUControl;
    logic [1:0]       PCSrc;
    logic             illegal;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Op, Funct, zero,
        output p_state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, instr_count
    );

    modport slave (
        output Op, Funct, zero,
        input  p_state, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc, illegal, instr_count
    );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Main control FSM for the multicycle MIPS core: sequences each instruction and
// drives datapath enables/selects, plus a retired-instruction counter and sticky illegal flag.
//
// state   | meaning
// FETCH   | read instr at PC into IR, PC <= PC+4
// DECODE  | read registers, precompute branch target into ALUOut
// MEMADR  | lw/sw effective address A+SignImm
// MEMRD   | lw data memory read
// MEMWB   | lw write memory data to rt
// MEMWR   | sw data memory write
// EXECUTE | R-type ALU op on A,B
// ALUWB   | R-type write ALUOut to rd
// BRANCH  | beq compare, PC <= ALUOut if equal
// ADDIEX  | addi A+SignImm
// ADDIWB  | addi write ALUOut to rt
// JUMP    | PC <= jump target
module mips_mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          reset,
    mips_mc_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;

    logic       funct_ok;
    logic [2:0] funct_alu;

    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] pc_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= FETCH;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (bus.Funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        illegal_d     = illegal_q;
        instr_count_d = instr_count_q;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:  state_d = (bus.Op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   state_d = MEMWB;
            EXECUTE: begin
                state_d = ALUWB;
                if (!funct_ok) illegal_d = 1'b1;
            end
            ADDIEX:  state_d = ADDIWB;
            MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP: begin
                state_d       = FETCH;
                instr_count_d = instr_count_q + CNT_W'(1);
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write    = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = ALU_ADD;
                pc_write    = 1'b1;
            end
            DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
            end
            MEMRD: iord = 1'b1;
            MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            EXECUTE: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
            end
            // IR is stable through ALUWB, so an unsupported Funct still blocks the write here
            ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = funct_ok;
            end
            ADDIWB: reg_write = 1'b1;
            BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = ALU_SUB;
                pc_src      = 2'b01;
                branch      = 1'b1;
            end
            JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.p_state     = state_q;
    assign bus.PCEn        = pc_write | (branch & bus.zero);
    assign bus.IorD        = iord;
    assign bus.MemWrite    = mem_write;
    assign bus.IRWrite     = ir_write;
    assign bus.RegDst      = reg_dst;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUControl  = alu_control;
    assign bus.PCSrc       = pc_src;
    assign bus.illegal     = illegal_q;
    assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl: walks each instruction class through its state
// sequence and checks outputs against hand-derived values.
module tb_mips_mc_ctrl;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mips_mc_ctrl_if #(.CNT_W(32)) bus ();

    mips_mc_ctrl #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.Op    = 6'd0;
        bus.Funct = 6'd0;
        bus.zero  = 1'b0;
        #2;
        checks++;
        if (bus.p_state !== 4'd0) begin
            errors++; $display("FAIL reset_state: got %0d expected 0", bus.p_state);
        end
        checks++;
        if (bus.instr_count !== 32'd0 || bus.illegal !== 1'b0) begin
            errors++; $display("FAIL reset_regs: count=%0d illegal=%b expected 0/0", bus.instr_count, bus.illegal);
        end
        checks++;
        if (bus.PCEn !== 1'b1 || bus.IRWrite !== 1'b1) begin
            errors++; $display("FAIL reset_fetch_decode: PCEn=%b IRWrite=%b expected 1/1", bus.PCEn, bus.IRWrite);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lw();
        logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        bus.Op    = 6'b100011;
        bus.Funct = 6'b000100;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.p_state !== exp_s[i]) begin
                errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, bus.p_state, exp_s[i]);
            end
            checks++;
            if (bus.RegWrite !== (exp_s[i] == 4'd4) || bus.MemtoReg !== (exp_s[i] == 4'd4)) begin
                errors++; $display("FAIL lw_wb[%0d]: RegWrite=%b MemtoReg=%b expected %b", i, bus.RegWrite, bus.MemtoReg, exp_s[i] == 4'd4);
            end
            checks++;
            if (bus.IorD !== (exp_s[i] == 4'd3)) begin
                errors++; $display("FAIL lw_iord[%0d]: got %b expected %b", i, bus.IorD, exp_s[i] == 4'd3);
            end
            if (i < 5) step();
        end
        checks++;
        if (bus.instr_count !== 32'd1) begin
            errors++; $display("FAIL lw_count: got %0d expected 1", bus.instr_count);
        end
    endtask

    task automatic test_sw();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        bus.Op    = 6'b101011;
        bus.Funct = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.p_state !== exp_s[i]) begin
                errors++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, bus.p_state, exp_s[i]);
            end
            checks++;
            if (bus.MemWrite !== (exp_s[i] == 4'd5) || bus.IorD !== (exp_s[i] == 4'd5)) begin
                errors++; $display("FAIL sw_mem[%0d]: MemWrite=%b IorD=%b expected %b", i, bus.MemWrite, bus.IorD, exp_s[i] == 4'd5);
            end
            if (i < 4) step();
        end
        checks++;
        if (bus.instr_count !== 32'd2) begin
            errors++; $display("FAIL sw_count: got %0d expected 2", bus.instr_count);
        end
    endtask

    task automatic test_rtype();
        logic [5:0] fn  [2] = '{6'b100000, 6'b101010};
        logic [2:0] alu [2] = '{3'b010, 3'b111};
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        bus.Op = 6'b000000;
        for (int k = 0; k < 2; k++) begin
            bus.Funct = fn[k];
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (bus.p_state !== exp_s[i]) begin
                    errors++; $display("FAIL rtype%0d_state[%0d]: got %0d expected %0d", k, i, bus.p_state, exp_s[i]);
                end
                if (exp_s[i] == 4'd6) begin
                    checks++;
                    if (bus.ALUControl !== alu[k] || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b00) begin
                        errors++; $display("FAIL rtype%0d_exec: ALUControl=%b SrcA=%b SrcB=%b expected %b/1/00", k, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, alu[k]);
                    end
                end
                if (exp_s[i] == 4'd7) begin
                    checks++;
                    if (bus.RegDst !== 1'b1 || bus.RegWrite !== 1'b1 || bus.MemtoReg !== 1'b0) begin
                        errors++; $display("FAIL rtype%0d_wb: RegDst=%b RegWrite=%b MemtoReg=%b expected 1/1/0", k, bus.RegDst, bus.RegWrite, bus.MemtoReg);
                    end
                end
                if (i < 4) step();
            end
        end
        checks++;
        if (bus.instr_count !== 32'd4) begin
            errors++; $display("FAIL rtype_count: got %0d expected 4", bus.instr_count);
        end
    endtask

    task automatic test_beq();
        logic       zv  [2] = '{1'b1, 1'b0};
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd8, 4'd0};
        bus.Op    = 6'b000100;
        bus.Funct = 6'b000011;
        for (int k = 0; k < 2; k++) begin
            bus.zero = zv[k];
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.p_state !== exp_s[i]) begin
                    errors++; $display("FAIL beq%0d_state[%0d]: got %0d expected %0d", k, i, bus.p_state, exp_s[i]);
                end
                if (exp_s[i] == 4'd8) begin
                    checks++;
                    if (bus.PCEn !== zv[k] || bus.PCSrc !== 2'b01 || bus.ALUControl !== 3'b110) begin
                        errors++; $display("FAIL beq%0d_branch: PCEn=%b PCSrc=%b ALUControl=%b expected %b/01/110", k, bus.PCEn, bus.PCSrc, bus.ALUControl, zv[k]);
                    end
                end
                if (i < 3) step();
            end
        end
        bus.zero = 1'b0;
        checks++;
        if (bus.instr_count !== 32'd6) begin
            errors++; $display("FAIL beq_count: got %0d expected 6", bus.instr_count);
        end
    endtask

    task automatic test_illegal_op();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        bus.Op = 6'b111111;
        checks++;
        if (bus.illegal !== 1'b0) begin
            errors++; $display("FAIL ill_pre: got %b expected 0", bus.illegal);
        end
        step();
        checks++;
        if (bus.p_state !== 4'd1) begin
            errors++; $display("FAIL ill_decode: got %0d expected 1", bus.p_state);
        end
        step();
        checks++;
        if (bus.p_state !== 4'd0 || bus.illegal !== 1'b1 || bus.instr_count !== 32'd6) begin
            errors++; $display("FAIL ill_abort: state=%0d illegal=%b count=%0d expected 0/1/6", bus.p_state, bus.illegal, bus.instr_count);
        end
        bus.Op = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.p_state !== exp_s[i] || bus.illegal !== 1'b1) begin
                errors++; $display("FAIL addi_state[%0d]: state=%0d illegal=%b expected %0d/1", i, bus.p_state, bus.illegal, exp_s[i]);
            end
            if (exp_s[i] == 4'd9) begin
                checks++;
                if (bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'b10 || bus.ALUControl !== 3'b010) begin
                    errors++; $display("FAIL addi_ex: SrcA=%b SrcB=%b ALU=%b expected 1/10/010", bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl);
                end
            end
            if (exp_s[i] == 4'd10) begin
                checks++;
                if (bus.RegWrite !== 1'b1 || bus.RegDst !== 1'b0) begin
                    errors++; $display("FAIL addi_wb: RegWrite=%b RegDst=%b expected 1/0", bus.RegWrite, bus.RegDst);
                end
            end
            if (i < 4) step();
        end
        checks++;
        if (bus.instr_count !== 32'd7) begin
            errors++; $display("FAIL addi_count: got %0d expected 7", bus.instr_count);
        end
    endtask

    task automatic test_jump();
        logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd11, 4'd0};
        bus.Op = 6'b000010;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.p_state !== exp_s[i]) begin
                errors++; $display("FAIL j_state[%0d]: got %0d expected %0d", i, bus.p_state, exp_s[i]);
            end
            if (exp_s[i] == 4'd11) begin
                checks++;
                if (bus.PCEn !== 1'b1 || bus.PCSrc !== 2'b10) begin
                    errors++; $display("FAIL j_pc: PCEn=%b PCSrc=%b expected 1/10", bus.PCEn, bus.PCSrc);
                end
            end
            if (i < 3) step();
        end
        checks++;
        if (bus.instr_count !== 32'd8) begin
            errors++; $display("FAIL j_count: got %0d expected 8", bus.instr_count);
        end
    endtask

    task automatic test_reset_mid();
        bus.Op = 6'b101011;
        step();
        step();
        step();
        checks++;
        if (bus.p_state !== 4'd5 || bus.MemWrite !== 1'b1) begin
            errors++; $display("FAIL mid_pre: state=%0d MemWrite=%b expected 5/1", bus.p_state, bus.MemWrite);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.p_state !== 4'd0 || bus.MemWrite !== 1'b0) begin
            errors++; $display("FAIL mid_abort: state=%0d MemWrite=%b expected 0/0", bus.p_state, bus.MemWrite);
        end
        checks++;
        if (bus.instr_count !== 32'd0 || bus.illegal !== 1'b0) begin
            errors++; $display("FAIL mid_regs: count=%0d illegal=%b expected 0/0", bus.instr_count, bus.illegal);
        end
        #2;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bad_funct();
        logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        bus.Op    = 6'b000000;
        bus.Funct = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.p_state !== exp_s[i]) begin
                errors++; $display("FAIL badfn_state[%0d]: got %0d expected %0d", i, bus.p_state, exp_s[i]);
            end
            checks++;
            if (bus.illegal !== (i >= 3)) begin
                errors++; $display("FAIL badfn_illegal[%0d]: got %b expected %b", i, bus.illegal, i >= 3);
            end
            if (exp_s[i] == 4'd6) begin
                checks++;
                if (bus.ALUControl !== 3'b010) begin
                    errors++; $display("FAIL badfn_alu: got %b expected 010", bus.ALUControl);
                end
            end
            if (exp_s[i] == 4'd7) begin
                checks++;
                if (bus.RegWrite !== 1'b0) begin
                    errors++; $display("FAIL badfn_regwrite: got %b expected 0", bus.RegWrite);
                end
            end
            if (i < 4) step();
        end
        checks++;
        if (bus.instr_count !== 32'd1) begin
            errors++; $display("FAIL badfn_count: got %0d expected 1", bus.instr_count);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_illegal_op();
        test_jump();
        test_reset_mid();
        test_bad_funct();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
